// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller:
// FSM state encoding, init ROM contents and the execution-wait classifier.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_WAIT      = 3'd5,
        ST_IDLE      = 3'd6,
        ST_WRAP_LOAD = 3'd7
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2    = 8'hC0;

    localparam int INIT_LEN = 4;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] code;
        case (idx)
            2'd0:    code = LCD_CMD_FUNC_SET;
            2'd1:    code = LCD_CMD_DISP_ON;
            2'd2:    code = LCD_CMD_CLEAR;
            2'd3:    code = LCD_CMD_ENTRY;
            default: code = LCD_CMD_ENTRY;
        endcase
        return code;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_write_controller_if.sv
// Command write handshake between a requester and the LCD write controller.
interface lcd_write_controller_if;

    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);

endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter shared by every timed FSM state; done while the count is zero.
module lcd_delay_counter #(
    parameter int unsigned     WIDTH       = 20,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= RESET_VALUE;
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_write_controller.sv
// HD44780 write controller: power-up delay, init ROM, then handshaked single writes
// with setup/enable/hold/execution timing. Optional cursor auto-wrap: LCD_AUTO_WRAP_EN.
module lcd_write_controller
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 750000,
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned EN_CYCLES         = 12,
    parameter int unsigned HOLD_CYCLES       = 2,
    parameter int unsigned SHORT_WAIT_CYCLES = 2000,
    parameter int unsigned LONG_WAIT_CYCLES  = 82000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    lcd_write_controller_if.slave        cmd,
    output logic                         init_done,
    output logic                         LCD_ON,
    output logic                         LCD_RS,
    output logic                         LCD_EN,
    output logic                         LCD_RW,
    output logic [7:0]                   LCD_DATA
);

    localparam int unsigned MAX_CYCLES = (POWERUP_CYCLES > LONG_WAIT_CYCLES) ?
                                         POWERUP_CYCLES : LONG_WAIT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    lcd_state_e       state_r;
    lcd_state_e       state_nx_s;
    logic [2:0]       init_idx_r;
    logic [2:0]       init_idx_nx_s;
    logic             init_done_r;
    logic             init_done_nx_s;
    logic             on_r;
    logic             en_r;
    logic             ready_r;
    logic             rs_r;
    logic [7:0]       data_r;
    logic             latch_s;
    logic             latch_rs_s;
    logic [7:0]       latch_data_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_value_s;
    logic             cnt_done_s;

`ifdef LCD_AUTO_WRAP_EN
    logic             line_r;
    logic [4:0]       col_r;
`endif

    lcd_delay_counter #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (CNT_W'(POWERUP_CYCLES - 1))
    ) u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load_s),
        .load_value (cnt_value_s),
        .done       (cnt_done_s)
    );

    // State register plus registered pin and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_PWRUP;
            init_idx_r  <= 3'd0;
            init_done_r <= 1'b0;
            on_r        <= 1'b0;
            en_r        <= 1'b0;
            ready_r     <= 1'b0;
            rs_r        <= 1'b0;
            data_r      <= 8'h00;
        end else begin
            state_r     <= state_nx_s;
            init_idx_r  <= init_idx_nx_s;
            init_done_r <= init_done_nx_s;
            on_r        <= 1'b1;
            en_r        <= (state_nx_s == ST_PULSE);
            ready_r     <= (state_nx_s == ST_IDLE);
            if (latch_s) begin
                rs_r   <= latch_rs_s;
                data_r <= latch_data_s;
            end else begin
                rs_r   <= rs_r;
                data_r <= data_r;
            end
        end
    end

    // Next-state, counter load and write-latch decode.
    always_comb begin
        state_nx_s     = state_r;
        init_idx_nx_s  = init_idx_r;
        init_done_nx_s = init_done_r;
        latch_s        = 1'b0;
        latch_rs_s     = 1'b0;
        latch_data_s   = 8'h00;
        cnt_load_s     = 1'b0;
        cnt_value_s    = {CNT_W{1'b0}};
        case (state_r)
            ST_PWRUP: begin
                if (cnt_done_s) begin
                    state_nx_s = ST_INIT_LOAD;
                end else begin
                    state_nx_s = ST_PWRUP;
                end
            end
            ST_INIT_LOAD: begin
                latch_s       = 1'b1;
                latch_rs_s    = 1'b0;
                latch_data_s  = init_rom(init_idx_r[1:0]);
                init_idx_nx_s = init_idx_r + 3'd1;
                cnt_load_s    = 1'b1;
                cnt_value_s   = CNT_W'(SETUP_CYCLES - 1);
                state_nx_s    = ST_SETUP;
            end
            ST_IDLE: begin
                if (cmd.cmd_valid && ready_r) begin
                    latch_s      = 1'b1;
                    latch_rs_s   = cmd.cmd_rs;
                    latch_data_s = cmd.cmd_data;
                    cnt_load_s   = 1'b1;
                    cnt_value_s  = CNT_W'(SETUP_CYCLES - 1);
                    state_nx_s   = ST_SETUP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_done_s) begin
                    cnt_load_s  = 1'b1;
                    cnt_value_s = CNT_W'(EN_CYCLES - 1);
                    state_nx_s  = ST_PULSE;
                end else begin
                    state_nx_s = ST_SETUP;
                end
            end
            ST_PULSE: begin
                if (cnt_done_s) begin
                    cnt_load_s  = 1'b1;
                    cnt_value_s = CNT_W'(HOLD_CYCLES - 1);
                    state_nx_s  = ST_HOLD;
                end else begin
                    state_nx_s = ST_PULSE;
                end
            end
            ST_HOLD: begin
                if (cnt_done_s) begin
                    cnt_load_s = 1'b1;
                    if (is_long_wait(rs_r, data_r)) begin
                        cnt_value_s = CNT_W'(LONG_WAIT_CYCLES - 1);
                    end else begin
                        cnt_value_s = CNT_W'(SHORT_WAIT_CYCLES - 1);
                    end
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (!cnt_done_s) begin
                    state_nx_s = ST_WAIT;
                end else if (!init_done_r) begin
                    if (init_idx_r == 3'(INIT_LEN)) begin
                        init_done_nx_s = 1'b1;
                        state_nx_s     = ST_IDLE;
                    end else begin
                        state_nx_s = ST_INIT_LOAD;
                    end
                end else begin
`ifdef LCD_AUTO_WRAP_EN
                    if (col_r == 5'd16) begin
                        state_nx_s = ST_WRAP_LOAD;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
`else
                    state_nx_s = ST_IDLE;
`endif
                end
            end
`ifdef LCD_AUTO_WRAP_EN
            ST_WRAP_LOAD: begin
                // The set-address command itself repositions the cursor via the latch path.
                latch_s      = 1'b1;
                latch_rs_s   = 1'b0;
                latch_data_s = line_r ? LCD_CMD_LINE1 : LCD_CMD_LINE2;
                cnt_load_s   = 1'b1;
                cnt_value_s  = CNT_W'(SETUP_CYCLES - 1);
                state_nx_s   = ST_SETUP;
            end
`endif
            default: begin
                state_nx_s = ST_PWRUP;
            end
        endcase
    end

`ifdef LCD_AUTO_WRAP_EN
    // Cursor tracking from every latched write, including init and wrap commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= 1'b0;
            col_r  <= 5'd0;
        end else if (!latch_s) begin
            line_r <= line_r;
            col_r  <= col_r;
        end else if (latch_rs_s) begin
            col_r <= col_r + 5'd1;
        end else if (is_long_wait(latch_rs_s, latch_data_s)) begin
            line_r <= 1'b0;
            col_r  <= 5'd0;
        end else if (latch_data_s[7]) begin
            line_r <= latch_data_s[6];
            col_r  <= {1'b0, latch_data_s[3:0]};
        end else begin
            line_r <= line_r;
            col_r  <= col_r;
        end
    end
`endif

    assign cmd.cmd_ready = ready_r;
    assign init_done     = init_done_r;
    assign LCD_ON        = on_r;
    assign LCD_RS        = rs_r;
    assign LCD_EN        = en_r;
    assign LCD_RW        = 1'b0;
    assign LCD_DATA      = data_r;

endmodule

// File: tb/tb_lcd_write_controller.sv
// Directed bench for lcd_write_controller with shortened power-up and wait times.
module tb_lcd_write_controller;

    localparam int unsigned P_PWRUP = 100;
    localparam int unsigned P_SHORT = 20;
    localparam int unsigned P_LONG  = 200;

    logic       clk;
    logic       rst_n;
    logic       init_done;
    logic       LCD_ON;
    logic       LCD_RS;
    logic       LCD_EN;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    logic [7:0] init_codes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    // Cycles to each init EN rise: from LCD_ON for the first, else from the previous EN fall.
    int         init_gaps  [4] = '{102, 25, 25, 205};

    lcd_write_controller_if cmd_if ();

    lcd_write_controller #(
        .POWERUP_CYCLES    (P_PWRUP),
        .SETUP_CYCLES      (2),
        .EN_CYCLES         (12),
        .HOLD_CYCLES       (2),
        .SHORT_WAIT_CYCLES (P_SHORT),
        .LONG_WAIT_CYCLES  (P_LONG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .init_done (init_done),
        .LCD_ON    (LCD_ON),
        .LCD_RS    (LCD_RS),
        .LCD_EN    (LCD_EN),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input int limit, output int n);
        n = 0;
        while (LCD_EN !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_width(output int w);
        w = 0;
        while (LCD_EN === 1'b1 && w < 100) begin
            w++;
            step();
        end
    endtask

    task automatic wait_ready_or_en(input int limit, output int n, output logic en_first);
        n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && LCD_EN !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        en_first = (LCD_EN === 1'b1);
    endtask

    // Releases reset (caller holds it low) and checks the full init sequence.
    task automatic run_init(input string pfx);
        int   n;
        int   w;
        logic ef;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq({pfx, "_on_pre"}, 32'(LCD_ON), 32'd0);
        step();
        check_eq({pfx, "_on"}, 32'(LCD_ON), 32'd1);
        check_eq({pfx, "_rw"}, 32'(LCD_RW), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_en(init_gaps[i] + 50, n);
            check_eq($sformatf("%s_gap%0d", pfx, i), 32'(n), 32'(init_gaps[i]));
            check_eq($sformatf("%s_code%0d", pfx, i), 32'(LCD_DATA), 32'(init_codes[i]));
            check_eq($sformatf("%s_rs%0d", pfx, i), 32'(LCD_RS), 32'd0);
            check_eq($sformatf("%s_busy%0d", pfx, i), 32'(init_done), 32'd0);
            pulse_width(w);
            check_eq($sformatf("%s_width%0d", pfx, i), 32'(w), 32'd12);
        end
        wait_ready_or_en(100, n, ef);
        check_eq({pfx, "_ready_gap"}, 32'(n), 32'd22);
        check_eq({pfx, "_ready_en"}, 32'(ef), 32'd0);
        check_eq({pfx, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    // One handshaked write; returns cycles from EN fall to the next ready or EN rise.
    task automatic do_write(input string tag, input logic rs, input logic [7:0] d,
                            output int n_after, output logic en_first);
        int n;
        int w;
        n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = rs;
        cmd_if.cmd_data  = d;
        step();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rs    = ~rs;
        cmd_if.cmd_data  = ~d;
        check_eq({tag, "_ready_drop"}, 32'(cmd_if.cmd_ready), 32'd0);
        check_eq({tag, "_rs"}, 32'(LCD_RS), 32'(rs));
        check_eq({tag, "_data"}, 32'(LCD_DATA), 32'(d));
        wait_en(50, n);
        check_eq({tag, "_setup"}, 32'(n), 32'd2);
        check_eq({tag, "_pulse_data"}, 32'(LCD_DATA), 32'(d));
        check_eq({tag, "_pulse_rs"}, 32'(LCD_RS), 32'(rs));
        pulse_width(w);
        check_eq({tag, "_width"}, 32'(w), 32'd12);
        wait_ready_or_en(500, n_after, en_first);
    endtask

    // Expects 16 character writes, then (with wrap) an autonomous set-address pulse.
    task automatic write_line(input string tag, input logic [7:0] wrap_code);
        int   n;
        int   w;
        logic ef;
        for (int i = 0; i < 16; i++) begin
            do_write($sformatf("%s_c%0d", tag, i), 1'b1, 8'(8'h41 + i), n, ef);
            if (i < 15) begin
                check_eq($sformatf("%s_gap%0d", tag, i), 32'(n), 32'd22);
            end else begin
`ifdef LCD_AUTO_WRAP_EN
                check_eq({tag, "_wrap_en"}, 32'(ef), 32'd1);
                check_eq({tag, "_wrap_gap"}, 32'(n), 32'd25);
                check_eq({tag, "_wrap_ready"}, 32'(cmd_if.cmd_ready), 32'd0);
                check_eq({tag, "_wrap_code"}, 32'(LCD_DATA), 32'(wrap_code));
                check_eq({tag, "_wrap_rs"}, 32'(LCD_RS), 32'd0);
                pulse_width(w);
                check_eq({tag, "_wrap_width"}, 32'(w), 32'd12);
                wait_ready_or_en(100, n, ef);
                check_eq({tag, "_wrap_after"}, 32'(n), 32'd22);
`else
                check_eq({tag, "_nowrap_en"}, 32'(ef), 32'd0);
                check_eq({tag, "_nowrap_gap"}, 32'(n), 32'd22);
                check_eq({tag, "_nowrap_code"}, 32'(wrap_code), 32'(wrap_code));
`endif
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   w;
        logic ef;
        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rs    = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) step();
        check_eq("rst_on", 32'(LCD_ON), 32'd0);
        check_eq("rst_en", 32'(LCD_EN), 32'd0);
        check_eq("rst_rs", 32'(LCD_RS), 32'd0);
        check_eq("rst_data", 32'(LCD_DATA), 32'd0);
        check_eq("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check_eq("rst_done", 32'(init_done), 32'd0);

        run_init("init1");

        // Character write: ready returns 2+12+2+20 cycles after transfer+1.
        do_write("chr41", 1'b1, 8'h41, n, ef);
        check_eq("chr41_ready_gap", 32'(n), 32'd22);
        check_eq("chr41_ready_en", 32'(ef), 32'd0);

        // Clear then a held-off write of 0x48 that must survive the long wait.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = 1'b0;
        cmd_if.cmd_data  = 8'h01;
        step();
        cmd_if.cmd_rs    = 1'b1;
        cmd_if.cmd_data  = 8'h48;
        check_eq("clr_data", 32'(LCD_DATA), 32'h01);
        wait_en(50, n);
        check_eq("clr_setup", 32'(n), 32'd2);
        pulse_width(w);
        check_eq("clr_width", 32'(w), 32'd12);
        wait_ready_or_en(400, n, ef);
        check_eq("clr_long_wait", 32'(n), 32'd202);
        check_eq("clr_no_early_en", 32'(ef), 32'd0);
        step();
        cmd_if.cmd_valid = 1'b0;
        check_eq("held_data", 32'(LCD_DATA), 32'h48);
        check_eq("held_rs", 32'(LCD_RS), 32'd1);
        wait_en(50, n);
        check_eq("held_setup", 32'(n), 32'd2);
        pulse_width(w);
        check_eq("held_width", 32'(w), 32'd12);
        wait_ready_or_en(100, n, ef);
        check_eq("held_ready_gap", 32'(n), 32'd22);

        // Home the cursor explicitly, then fill both lines.
        do_write("line0", 1'b0, 8'h80, n, ef);
        check_eq("line0_gap", 32'(n), 32'd22);
        write_line("lineA", 8'hC0);
        write_line("lineB", 8'h80);

        // Reset in the middle of an enable pulse.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = 1'b1;
        cmd_if.cmd_data  = 8'h5A;
        step();
        cmd_if.cmd_valid = 1'b0;
        wait_en(50, n);
        check_eq("mid_en_high", 32'(LCD_EN), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_en", 32'(LCD_EN), 32'd0);
        check_eq("mid_rst_done", 32'(init_done), 32'd0);
        check_eq("mid_rst_on", 32'(LCD_ON), 32'd0);
        check_eq("mid_rst_data", 32'(LCD_DATA), 32'd0);
        repeat (3) step();
        run_init("init2");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
